// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: receiver-detect state encoding, default timing, width helper.
package ltssm_pkg;

    typedef enum logic [2:0] {
        RXD_IDLE   = 3'd0,
        RXD_REQ    = 3'd1,
        RXD_WAIT   = 3'd2,
        RXD_SETTLE = 3'd3,
        RXD_GAP    = 3'd4,
        RXD_DONE   = 3'd5
    } rxd_state_e;

    localparam int unsigned RXD_TIMEOUT_DEF = 2000;
    localparam int unsigned RXD_SETTLE_DEF  = 16;
    localparam int unsigned RXD_RETRY_DEF   = 1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt;

    // Count up to LIMIT and hold there; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc_c = (cnt == LIM);

endmodule

// File: rtl/rx_detect_ctrl.sv
// Receiver-detect sequencer: drives per-lane detect requests, qualifies the
// delayed response for stability, bounds each attempt with a timeout/retry.
module rx_detect_ctrl
    import ltssm_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = RXD_TIMEOUT_DEF,
    parameter int unsigned SETTLE_CYCLES  = RXD_SETTLE_DEF,
    parameter int unsigned RETRY_MAX      = RXD_RETRY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lane_mask,
    output logic [WIDTH-1:0] det_req,
    input  logic [WIDTH-1:0] det_resp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lanes_found,
    output logic             timeout
);

    localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned SET_W = cnt_width(SETTLE_CYCLES + 1);
    localparam int unsigned RTY_W = cnt_width(RETRY_MAX + 1);

    rxd_state_e       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [WIDTH-1:0] lanes_d;
    logic             timeout_d;
    logic [WIDTH-1:0] resp_m;
    logic             tmo_clr, tmo_en, tmo_tc;
    logic             set_clr, set_en, set_tc;
    logic             attempt_end;

    // Attempt timer: zero in REQ, counts through REQ/WAIT/SETTLE.
    sat_counter #(.WIDTH(TMO_W), .LIMIT(TIMEOUT_CYCLES - 1)) u_tmo_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmo_clr),
        .en   (tmo_en),
        .tc_c (tmo_tc)
    );

    // Stability timer: counts consecutive unchanged cycles in SETTLE.
    sat_counter #(.WIDTH(SET_W), .LIMIT(SETTLE_CYCLES - 1)) u_set_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (set_clr),
        .en   (set_en),
        .tc_c (set_tc)
    );

    assign resp_m = det_resp & mask_q;

    // Next-state, counter control and result computation.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        snap_d      = snap_q;
        retry_d     = retry_q;
        lanes_d     = lanes_found;
        timeout_d   = timeout;
        tmo_clr     = 1'b1;
        tmo_en      = 1'b0;
        set_clr     = 1'b1;
        set_en      = 1'b0;
        attempt_end = 1'b0;

        case (state_q)
            RXD_IDLE: begin
                if (start) begin
                    mask_d    = lane_mask;
                    snap_d    = '0;
                    retry_d   = '0;
                    lanes_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = (lane_mask != '0) ? RXD_REQ : RXD_DONE;
                end
            end
            RXD_REQ: begin
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                state_d = RXD_WAIT;
            end
            RXD_WAIT: begin
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                if (tmo_tc) begin
                    attempt_end = 1'b1;
                end else if (resp_m != '0) begin
                    snap_d  = resp_m;
                    state_d = RXD_SETTLE;
                end
            end
            RXD_SETTLE: begin
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                if (resp_m != snap_q) begin
                    snap_d = resp_m;
                    attempt_end = tmo_tc;
                end else begin
                    set_clr = 1'b0;
                    set_en  = 1'b1;
                    if (set_tc) begin
                        // Settle completion wins over a same-cycle timeout.
                        lanes_d   = snap_q;
                        timeout_d = 1'b0;
                        state_d   = RXD_DONE;
                    end else begin
                        attempt_end = tmo_tc;
                    end
                end
            end
            RXD_GAP: begin
                snap_d  = '0;
                state_d = RXD_REQ;
            end
            RXD_DONE: begin
                state_d = RXD_IDLE;
            end
            default: begin
                state_d = RXD_IDLE;
            end
        endcase

        // Expired attempt: retry through GAP or finish with timeout flagged.
        if (attempt_end) begin
            if (retry_q < RTY_W'(RETRY_MAX)) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = RXD_GAP;
            end else begin
                lanes_d   = snap_d;
                timeout_d = 1'b1;
                state_d   = RXD_DONE;
            end
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RXD_IDLE;
            mask_q      <= '0;
            snap_q      <= '0;
            retry_q     <= '0;
            det_req     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lanes_found <= '0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            snap_q      <= snap_d;
            retry_q     <= retry_d;
            det_req     <= ((state_d == RXD_REQ) || (state_d == RXD_WAIT) ||
                            (state_d == RXD_SETTLE)) ? mask_d : '0;
            busy        <= (state_d != RXD_IDLE);
            done        <= (state_d == RXD_DONE);
            lanes_found <= lanes_d;
            timeout     <= timeout_d;
        end
    end

endmodule
